fifo_12bit: RTL and testbench
=============================

Name: fifo_12bit

Overview:
Synchronous single-clock first-in/first-out buffer for 12-bit data words. It sits between a producer and a consumer in the same clock domain. It provides registered read data and full/empty status flags. Writes and reads are qualified by enables and may occur in the same cycle.

Parameters:
WIDTH, 12, data word width in bits
DEPTH, 16, number of storage entries; must be a power of two, minimum 2
ADDR_W, 4, pointer/address width; must equal log2(DEPTH)

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  asynchronous, active-high reset
wr_en  input  1  write request, sampled on the rising edge of clk
rd_en  input  1  read request, sampled on the rising edge of clk
data_in  input  WIDTH  write data, captured when a write is accepted
data_out  output  WIDTH  registered read data
full  output  1  high when DEPTH entries are stored
empty  output  1  high when no entries are stored

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Reset (rst=1, takes effect immediately, independent of clk):
  - write pointer = 0, read pointer = 0
  - data_out = 0, empty = 1, full = 0
  - storage array contents are not cleared
  - Reset mid-operation discards all stored entries.
  - First accepted write after rst deasserts lands in entry 0.
- Pointers: write and read pointers are each ADDR_W+1 bits.
  - The low ADDR_W bits address the storage array.
  - The MSB is a wrap bit; pointers wrap modulo 2*DEPTH.
  - empty = (wr_ptr == rd_ptr).
  - full = (address bits equal) AND (wrap bits differ).
  - Both flags are derived combinationally from the registered pointers, so they update in the same edge as the pointer change. Zero-latency flags.
- Write accept: wr_en=1 AND full=0 at the rising edge.
  - mem[wr_ptr] <= data_in; wr_ptr increments by 1.
  - wr_en while full is ignored: no storage change, no pointer change, no error output.
- Read accept: rd_en=1 AND empty=0 at the rising edge.
  - data_out <= mem[rd_ptr]; rd_ptr increments by 1.
  - Read latency is one clock: data is valid on data_out after the accepting edge.
  - rd_en while empty is ignored: data_out holds its previous value and rd_ptr does not change.
- data_out holds its last read value until the next accepted read or a reset.
- Simultaneous wr_en and rd_en:
  - Each is accepted independently per the rules above, using pre-edge flag values.
  - When neither flag is set, both operations proceed; occupancy is unchanged and flags are unchanged.
  - When empty: only the write is accepted; data_out is not updated that cycle (no write-through bypass).
  - When full: only the read is accepted; the write is dropped.
- Ordering: data is returned strictly in write order across pointer wrap-around.

Test Plan:
- Reset: rst=1 for 25 ns then low -> data_out=0, empty=1, full=0. Assert rst mid-test with 3 entries stored -> empty=1 and data_out=0 immediately, without waiting for a clock edge.
- Basic write/read: write 100, 200, 300, 400 on consecutive edges -> empty falls after the first write, full=0. Four separated single-cycle reads -> data_out = 100, 200, 300, 400, each valid one clock after its rd_en edge. After the fourth read, empty=1.
- Fill to full: write 16 words (1..16) -> full=1 after the 16th edge. A 17th write of 999 is dropped. Read all 16 -> sequence 1..16, no 999, empty=1.
- Underflow: rd_en=1 for 3 cycles while empty, last read value was 400 -> data_out stays 400, pointers unchanged, empty stays 1.
- Simultaneous read/write:
  - With 2 entries (10, 20): write 30 and read together -> data_out=10, occupancy stays 2.
  - While empty: wr_en+rd_en with 55 -> only the write is accepted, data_out unchanged, empty falls.
  - While full: wr_en+rd_en -> only the read is accepted, full falls.
- Wrap-around: write and read 40 words in an interleaved pattern, occupancy between 1 and 5 -> output equals input order exactly, and empty/full stay correct across pointer wraps.

Source files
------------

// File: rtl/fifo_12bit.sv
// rtl/fifo_12bit.sv - single-clock FIFO with registered read data and zero-latency full/empty flags
module fifo_12bit #(
    parameter int WIDTH  = 12,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;
    logic             wr_accept;
    logic             rd_accept;

    // Extra MSB on each pointer is a wrap bit that separates full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                   (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    // Storage is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr[ADDR_W-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (wr_accept) begin
            wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            data_out <= '0;
        end else if (rd_accept) begin
            rd_ptr   <= rd_ptr + PTR_ONE;
            data_out <= mem[rd_ptr[ADDR_W-1:0]];
        end
    end

endmodule

// File: tb/tb_fifo_12bit.sv
// tb/tb_fifo_12bit.sv - directed self-checking bench for fifo_12bit
module tb_fifo_12bit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [11:0] data_in = '0;
    logic [11:0] data_out;
    logic        full;
    logic        empty;

    int tests = 0;
    int failed = 0;

    fifo_12bit #(.WIDTH(12), .DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .data_in(data_in),
        .data_out(data_out),
        .full(full),
        .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic cycle(input logic we, input logic re, input logic [11:0] din);
        wr_en = we;
        rd_en = re;
        data_in = din;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset;
        #25 rst = 1'b0;
        @(posedge clk);
        #1;
        tests++; if (data_out !== 12'd0) begin failed++; $display("FAIL reset_data_out got=%0d exp=0", data_out); end
        tests++; if (empty !== 1'b1) begin failed++; $display("FAIL reset_empty got=%b exp=1", empty); end
        tests++; if (full !== 1'b0) begin failed++; $display("FAIL reset_full got=%b exp=0", full); end
    endtask

    task automatic test_basic;
        logic [11:0] vals [4] = '{12'd100, 12'd200, 12'd300, 12'd400};
        cycle(1'b1, 1'b0, vals[0]);
        tests++; if (empty !== 1'b0) begin failed++; $display("FAIL basic_empty_fall got=%b exp=0", empty); end
        for (int i = 1; i < 4; i++) cycle(1'b1, 1'b0, vals[i]);
        tests++; if (full !== 1'b0) begin failed++; $display("FAIL basic_full got=%b exp=0", full); end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 12'd0);
            tests++; if (data_out !== vals[i]) begin failed++; $display("FAIL basic_read%0d got=%0d exp=%0d", i, data_out, vals[i]); end
            cycle(1'b0, 1'b0, 12'd0);
        end
        tests++; if (empty !== 1'b1) begin failed++; $display("FAIL basic_empty_end got=%b exp=1", empty); end
    endtask

    task automatic test_underflow;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 12'd0);
            tests++; if (data_out !== 12'd400) begin failed++; $display("FAIL underflow_data%0d got=%0d exp=400", i, data_out); end
            tests++; if (empty !== 1'b1) begin failed++; $display("FAIL underflow_empty%0d got=%b exp=1", i, empty); end
        end
    endtask

    task automatic test_fill;
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, 1'b0, 12'(i));
            if (i == 15) begin
                tests++; if (full !== 1'b0) begin failed++; $display("FAIL fill_full_at15 got=%b exp=0", full); end
            end
        end
        tests++; if (full !== 1'b1) begin failed++; $display("FAIL fill_full_at16 got=%b exp=1", full); end
        cycle(1'b1, 1'b0, 12'd999);
        tests++; if (full !== 1'b1) begin failed++; $display("FAIL fill_overflow_full got=%b exp=1", full); end
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b0, 1'b1, 12'd0);
            tests++; if (data_out !== 12'(i)) begin failed++; $display("FAIL fill_read%0d got=%0d exp=%0d", i, data_out, i); end
            if (i == 1) begin
                tests++; if (full !== 1'b0) begin failed++; $display("FAIL fill_full_fall got=%b exp=0", full); end
            end
        end
        tests++; if (empty !== 1'b1) begin failed++; $display("FAIL fill_empty_end got=%b exp=1", empty); end
    endtask

    task automatic test_simultaneous;
        cycle(1'b1, 1'b0, 12'd10);
        cycle(1'b1, 1'b0, 12'd20);
        cycle(1'b1, 1'b1, 12'd30);
        tests++; if (data_out !== 12'd10) begin failed++; $display("FAIL simul_mid_data got=%0d exp=10", data_out); end
        tests++; if (empty !== 1'b0 || full !== 1'b0) begin failed++; $display("FAIL simul_mid_flags got=%b%b exp=00", empty, full); end
        cycle(1'b0, 1'b1, 12'd0);
        tests++; if (data_out !== 12'd20) begin failed++; $display("FAIL simul_mid_rd2 got=%0d exp=20", data_out); end
        cycle(1'b0, 1'b1, 12'd0);
        tests++; if (data_out !== 12'd30) begin failed++; $display("FAIL simul_mid_rd3 got=%0d exp=30", data_out); end
        tests++; if (empty !== 1'b1) begin failed++; $display("FAIL simul_mid_occupancy got=%b exp=1", empty); end

        cycle(1'b1, 1'b1, 12'd55);
        tests++; if (data_out !== 12'd30) begin failed++; $display("FAIL simul_empty_data got=%0d exp=30", data_out); end
        tests++; if (empty !== 1'b0) begin failed++; $display("FAIL simul_empty_flag got=%b exp=0", empty); end
        cycle(1'b0, 1'b1, 12'd0);
        tests++; if (data_out !== 12'd55) begin failed++; $display("FAIL simul_empty_rd got=%0d exp=55", data_out); end

        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 12'(500 + i));
        tests++; if (full !== 1'b1) begin failed++; $display("FAIL simul_full_pre got=%b exp=1", full); end
        cycle(1'b1, 1'b1, 12'd777);
        tests++; if (data_out !== 12'd500) begin failed++; $display("FAIL simul_full_data got=%0d exp=500", data_out); end
        tests++; if (full !== 1'b0) begin failed++; $display("FAIL simul_full_flag got=%b exp=0", full); end
        for (int i = 1; i < 16; i++) cycle(1'b0, 1'b1, 12'd0);
        tests++; if (data_out !== 12'd515) begin failed++; $display("FAIL simul_full_last got=%0d exp=515", data_out); end
        tests++; if (empty !== 1'b1) begin failed++; $display("FAIL simul_full_dropped got=%b exp=1", empty); end
    endtask

    task automatic test_wrap;
        logic [11:0] q[$];
        logic [11:0] exp;
        int written;
        int n;
        cycle(1'b1, 1'b0, 12'd1000);
        q.push_back(12'd1000);
        written = 1;
        while (written < 40) begin
            n = (40 - written < 4) ? 40 - written : 4;
            for (int i = 0; i < n; i++) begin
                exp = 12'(1000 + written);
                cycle(1'b1, 1'b0, exp);
                q.push_back(exp);
                written++;
                tests++; if (empty !== 1'b0 || full !== 1'b0) begin failed++; $display("FAIL wrap_wr_flags%0d got=%b%b exp=00", written, empty, full); end
            end
            for (int i = 0; i < n; i++) begin
                cycle(1'b0, 1'b1, 12'd0);
                exp = q.pop_front();
                tests++; if (data_out !== exp) begin failed++; $display("FAIL wrap_rd got=%0d exp=%0d", data_out, exp); end
                tests++; if (empty !== 1'b0) begin failed++; $display("FAIL wrap_rd_empty got=%b exp=0", empty); end
            end
        end
        cycle(1'b0, 1'b1, 12'd0);
        exp = q.pop_front();
        tests++; if (data_out !== exp) begin failed++; $display("FAIL wrap_drain got=%0d exp=%0d", data_out, exp); end
        tests++; if (empty !== 1'b1) begin failed++; $display("FAIL wrap_empty_end got=%b exp=1", empty); end
    endtask

    task automatic test_reset_mid;
        cycle(1'b1, 1'b0, 12'd71);
        cycle(1'b1, 1'b0, 12'd72);
        cycle(1'b1, 1'b0, 12'd73);
        tests++; if (empty !== 1'b0) begin failed++; $display("FAIL rstmid_pre_empty got=%b exp=0", empty); end
        #1 rst = 1'b1;
        #1;
        tests++; if (empty !== 1'b1) begin failed++; $display("FAIL rstmid_empty got=%b exp=1", empty); end
        tests++; if (data_out !== 12'd0) begin failed++; $display("FAIL rstmid_data got=%0d exp=0", data_out); end
        tests++; if (full !== 1'b0) begin failed++; $display("FAIL rstmid_full got=%b exp=0", full); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 12'd42);
        cycle(1'b0, 1'b1, 12'd0);
        tests++; if (data_out !== 12'd42) begin failed++; $display("FAIL rstmid_after got=%0d exp=42", data_out); end
        tests++; if (empty !== 1'b1) begin failed++; $display("FAIL rstmid_after_empty got=%b exp=1", empty); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_fill();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
